// File: rtl/vec_mmio_bridge_if.sv
// Bus and vector-register-file signal bundle for vec_mmio_bridge.
// The slave modport is the bridge side; the master modport is the core/register-file side.
interface vec_mmio_bridge_if #(
    parameter int ADDR_W = 16,
    parameter int LANES  = 8,
    parameter int LANE_W = 32,
    parameter int NREGS  = 8
);
    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [ADDR_W-1:0]       addr;
    logic [LANE_W-1:0]       wdata;
    logic                    we;
    logic [LANE_W-1:0]       rdata;
    logic                    hit;
    logic                    busy;
    logic                    vec_wr_valid;
    logic                    vec_wr_ready;
    logic [IDX_W-1:0]        vec_wr_idx;
    logic [LANES*LANE_W-1:0] vec_wr_data;
    logic                    vec_rd_req;
    logic [IDX_W-1:0]        vec_rd_idx;
    logic                    vec_rd_valid;
    logic [LANES*LANE_W-1:0] vec_rd_data;

    modport slave (
        input  addr, wdata, we, vec_wr_ready, vec_rd_valid, vec_rd_data,
        output rdata, hit, busy, vec_wr_valid, vec_wr_idx, vec_wr_data, vec_rd_req, vec_rd_idx
    );

    modport master (
        output addr, wdata, we, vec_wr_ready, vec_rd_valid, vec_rd_data,
        input  rdata, hit, busy, vec_wr_valid, vec_wr_idx, vec_wr_data, vec_rd_req, vec_rd_idx
    );
endinterface

// File: rtl/vec_mmio_bridge.sv
// Memory-mapped bridge: the core builds a vector lane by lane, commits it to a vector
// register, or fetches a vector register back into the lane buffer for scalar reads.
module vec_mmio_bridge #(
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 256,
    parameter int LANES     = 8,
    parameter int LANE_W    = 32,
    parameter int NREGS     = 8
) (
    input logic              clk,
    input logic              rst,
    vec_mmio_bridge_if.slave bus
);
    localparam int IDX_W  = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [ADDR_W:0] WIN_LO = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] WIN_HI = (ADDR_W+1)'(BASE_ADDR + LANES + 2);

    typedef enum logic [1:0] {ST_IDLE, ST_COMMIT, ST_FETCH} state_t;

    state_t                  r_state, w_next_state;
    logic [LANE_W-1:0]       r_buf [LANES];
    logic [LANES-1:0]        r_mask;
    logic                    r_err;
    logic                    r_wr_valid;
    logic                    r_rd_req;
    logic [IDX_W-1:0]        r_wr_idx;
    logic [IDX_W-1:0]        r_rd_idx;
    logic [LANE_W-1:0]       r_rdata;

    logic [ADDR_W-1:0]       w_off;
    logic [LIDX_W-1:0]       w_lane;
    logic                    w_is_lane, w_is_commit, w_is_status, w_is_fetch;
    logic                    w_idx_ok, w_busy;
    logic                    w_lane_wr, w_commit_go, w_fetch_go, w_wr_done, w_rd_done;
    logic                    w_err_set, w_err_clr;
    logic [LANE_W-1:0]       w_status, w_rdata_next;
    logic [LANES*LANE_W-1:0] w_vec;

    // Widened by one bit so the window end cannot wrap at the top of the address space.
    assign bus.hit = ({1'b0, bus.addr} >= WIN_LO) && ({1'b0, bus.addr} <= WIN_HI);

    assign w_off       = bus.addr - ADDR_W'(BASE_ADDR);
    assign w_lane      = w_off[LIDX_W-1:0];
    assign w_is_lane   = bus.hit && (w_off <  ADDR_W'(LANES));
    assign w_is_commit = bus.hit && (w_off == ADDR_W'(LANES));
    assign w_is_status = bus.hit && (w_off == ADDR_W'(LANES + 1));
    assign w_is_fetch  = bus.hit && (w_off == ADDR_W'(LANES + 2));
    assign w_idx_ok    = bus.wdata < LANE_W'(NREGS);
    assign w_busy      = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Bus writes are judged against the current state, so a write landing in the
    // handshake-completion cycle is still rejected as busy.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_next_state = r_state;
        w_lane_wr    = 1'b0;
        w_commit_go  = 1'b0;
        w_fetch_go   = 1'b0;
        w_wr_done    = 1'b0;
        w_rd_done    = 1'b0;
        w_err_set    = 1'b0;
        w_err_clr    = 1'b0;

        if (bus.we) begin
            if (w_is_lane) begin
                if (w_busy) w_err_set = 1'b1;
                else        w_lane_wr = 1'b1;
            end else if (w_is_commit || w_is_fetch) begin
                if (!w_idx_ok || w_busy) w_err_set   = 1'b1;
                else if (w_is_commit)    w_commit_go = 1'b1;
                else                     w_fetch_go  = 1'b1;
            end else if (w_is_status) begin
                w_err_clr = bus.wdata[1];
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (w_commit_go)     w_next_state = ST_COMMIT;
                else if (w_fetch_go) w_next_state = ST_FETCH;
            end
            ST_COMMIT: begin
                if (r_wr_valid && bus.vec_wr_ready) begin
                    w_wr_done    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (bus.vec_rd_valid) begin
                    w_rd_done    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_status            = '0;
        w_status[0]         = w_busy;
        w_status[1]         = r_err;
        w_status[2 +: LANES] = r_mask;

        w_rdata_next = '0;
        if (w_is_lane)        w_rdata_next = r_buf[w_lane];
        else if (w_is_status) w_rdata_next = w_status;

        w_vec = '0;
        for (int i = 0; i < LANES; i++) w_vec[i*LANE_W +: LANE_W] = r_buf[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the lane buffer is architecturally visible after reset, so it is cleared
            // here like any other register rather than left uninitialised as a RAM would be.
            for (int i = 0; i < LANES; i++) r_buf[i] <= '0;
            r_mask     <= '0;
            r_err      <= 1'b0;
            r_wr_valid <= 1'b0;
            r_rd_req   <= 1'b0;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_rdata    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update here order-independent.
            r_rdata  <= w_rdata_next;
            r_rd_req <= w_fetch_go;

            if (w_lane_wr) begin
                r_buf[w_lane]  <= bus.wdata;
                r_mask[w_lane] <= 1'b1;
            end
            if (w_commit_go) begin
                r_wr_idx   <= bus.wdata[IDX_W-1:0];
                r_wr_valid <= 1'b1;
            end
            if (w_wr_done) begin
                r_wr_valid <= 1'b0;
                r_mask     <= '0;
            end
            if (w_fetch_go) r_rd_idx <= bus.wdata[IDX_W-1:0];
            if (w_rd_done) begin
                for (int i = 0; i < LANES; i++) r_buf[i] <= bus.vec_rd_data[i*LANE_W +: LANE_W];
                r_mask <= '0;
            end

            // A set in the same cycle as a clear wins.
            if (w_err_set)      r_err <= 1'b1;
            else if (w_err_clr) r_err <= 1'b0;
        end
    end

    assign bus.rdata        = r_rdata;
    assign bus.busy         = w_busy;
    assign bus.vec_wr_valid = r_wr_valid;
    assign bus.vec_wr_idx   = r_wr_idx;
    assign bus.vec_wr_data  = w_vec;
    assign bus.vec_rd_req   = r_rd_req;
    assign bus.vec_rd_idx   = r_rd_idx;
endmodule

// File: tb/tb_vec_mmio_bridge.sv
// Self-checking bench for vec_mmio_bridge: directed scenarios plus random traffic,
// compared against a transaction-level model of the lane buffer, mask and error flag.
module tb_vec_mmio_bridge;
    localparam int ADDR_W = 16;
    localparam int BASE   = 256;
    localparam int LANES  = 8;
    localparam int LANE_W = 32;
    localparam int NREGS  = 8;
    localparam int A_COMMIT = BASE + LANES;
    localparam int A_STATUS = BASE + LANES + 1;
    localparam int A_FETCH  = BASE + LANES + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vec_mmio_bridge_if #(.ADDR_W(ADDR_W), .LANES(LANES), .LANE_W(LANE_W), .NREGS(NREGS)) bus ();

    vec_mmio_bridge #(
        .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .LANES(LANES), .LANE_W(LANE_W), .NREGS(NREGS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference model: what the core should see, updated per transaction.
    logic [31:0] m_buf [LANES];
    logic [7:0]  m_mask;
    logic        m_err;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] exp_status(input logic busy);
        return {22'b0, m_mask, m_err, busy};
    endfunction

    function automatic logic [255:0] exp_vec();
        logic [255:0] v;
        for (int i = 0; i < LANES; i++) v[i*32 +: 32] = m_buf[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LANES; i++) m_buf[i] = '0;
        m_mask = '0;
        m_err  = 1'b0;
    endtask

    task automatic bus_write(input int a, input logic [31:0] d);
        @(negedge clk);
        bus.addr = ADDR_W'(a); bus.wdata = d; bus.we = 1'b1;
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic bus_read(input int a, output logic [31:0] v);
        @(negedge clk);
        bus.addr = ADDR_W'(a); bus.we = 1'b0;
        @(negedge clk);
        v = bus.rdata;
    endtask

    task automatic lane_write(input int l, input logic [31:0] d);
        bus_write(BASE + l, d);
        m_buf[l]  = d;
        m_mask[l] = 1'b1;
    endtask

    task automatic read_status(input string name);
        logic [31:0] v;
        bus_read(A_STATUS, v);
        n_vec++;
        if (v !== exp_status(1'b0)) begin
            n_err++;
            $display("FAIL %s status: got %h expected %h", name, v, exp_status(1'b0));
        end
    endtask

    task automatic read_lanes(input string name);
        logic [31:0] v;
        for (int i = 0; i < LANES; i++) begin
            bus_read(BASE + i, v);
            n_vec++;
            if (v !== m_buf[i]) begin
                n_err++;
                $display("FAIL %s lane%0d: got %h expected %h", name, i, v, m_buf[i]);
            end
        end
    endtask

    task automatic test_reset();
        int addrs [6] = '{255, 256, 264, 266, 267, 16'hFFFF};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        n_vec++;
        if ({bus.rdata, bus.vec_wr_valid, bus.vec_rd_req, bus.busy, bus.vec_wr_idx, bus.vec_rd_idx} !== '0) begin
            n_err++;
            $display("FAIL reset outputs: got rdata=%h wv=%b rq=%b busy=%b widx=%0d ridx=%0d expected all 0",
                     bus.rdata, bus.vec_wr_valid, bus.vec_rd_req, bus.busy, bus.vec_wr_idx, bus.vec_rd_idx);
        end
        foreach (addrs[k]) begin
            bus.addr = ADDR_W'(addrs[k]);
            #1;
            n_vec++;
            if (bus.hit !== (addrs[k] >= BASE && addrs[k] <= BASE + LANES + 2)) begin
                n_err++;
                $display("FAIL hit addr %0d: got %b expected %b", addrs[k], bus.hit,
                         addrs[k] >= BASE && addrs[k] <= BASE + LANES + 2);
            end
        end
        read_lanes("reset");
        read_status("reset");
    endtask

    task automatic test_lane_loads();
        logic [31:0] v;
        for (int i = 0; i < LANES; i++) lane_write(i, 32'((i + 1) * 32'h11));
        bus_read(A_STATUS, v);
        n_vec++;
        if (v !== 32'h3FC) begin
            n_err++;
            $display("FAIL load status: got %h expected %h", v, 32'h3FC);
        end
        read_lanes("load");
        bus_read(A_COMMIT, v);
        n_vec++;
        if (v !== 32'h0) begin
            n_err++;
            $display("FAIL write-only read: got %h expected 0", v);
        end
        for (int k = 0; k < 6; k++) lane_write($urandom_range(0, LANES - 1), $urandom);
        read_lanes("load_rand");
    endtask

    task automatic test_commit_backpressure();
        logic [31:0] v;
        bus.vec_wr_ready = 1'b0;
        bus_write(A_COMMIT, 3);
        for (int k = 0; k < 4; k++) begin
            bus.addr = ADDR_W'(BASE + k);
            @(negedge clk);
            n_vec++;
            if (bus.vec_wr_valid !== 1'b1 || bus.vec_wr_idx !== 3'd3 ||
                bus.vec_wr_data !== exp_vec() || bus.busy !== 1'b1) begin
                n_err++;
                $display("FAIL commit hold cyc%0d: got v=%b idx=%0d busy=%b data=%h expected v=1 idx=3 busy=1 data=%h",
                         k, bus.vec_wr_valid, bus.vec_wr_idx, bus.busy, bus.vec_wr_data, exp_vec());
            end
            n_vec++;
            if (bus.rdata !== m_buf[k]) begin
                n_err++;
                $display("FAIL busy lane read %0d: got %h expected %h", k, bus.rdata, m_buf[k]);
            end
        end
        bus.vec_wr_ready = 1'b1;
        @(negedge clk);
        bus.vec_wr_ready = 1'b0;
        m_mask = '0;
        n_vec++;
        if (bus.vec_wr_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL commit done: got v=%b busy=%b expected 0 0", bus.vec_wr_valid, bus.busy);
        end
        bus_read(A_STATUS, v);
        n_vec++;
        if (v !== 32'h0) begin
            n_err++;
            $display("FAIL commit status: got %h expected 0", v);
        end
    endtask

    task automatic test_partial_commit();
        lane_write(2, 32'hDEAD);
        bus.vec_wr_ready = 1'b1;
        bus_write(A_COMMIT, 1);
        n_vec++;
        if (bus.vec_wr_valid !== 1'b1 || bus.vec_wr_idx !== 3'd1 || bus.vec_wr_data[95:64] !== 32'hDEAD) begin
            n_err++;
            $display("FAIL partial commit: got v=%b idx=%0d lane2=%h expected v=1 idx=1 lane2=0000dead",
                     bus.vec_wr_valid, bus.vec_wr_idx, bus.vec_wr_data[95:64]);
        end
        n_vec++;
        if (bus.vec_wr_data !== exp_vec()) begin
            n_err++;
            $display("FAIL partial commit data: got %h expected %h", bus.vec_wr_data, exp_vec());
        end
        @(negedge clk);
        bus.vec_wr_ready = 1'b0;
        m_mask = '0;
        n_vec++;
        if (bus.vec_wr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL partial commit drop: got v=%b expected 0", bus.vec_wr_valid);
        end
        read_status("partial");
    endtask

    task automatic do_fetch(input int idx, input int lat, input logic [255:0] data, input string name);
        int pulses;
        bus_write(A_FETCH, idx);
        n_vec++;
        if (bus.vec_rd_req !== 1'b1 || bus.vec_rd_idx !== 3'(idx) || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s req: got rq=%b idx=%0d busy=%b expected rq=1 idx=%0d busy=1",
                     name, bus.vec_rd_req, bus.vec_rd_idx, bus.busy, idx);
        end
        pulses = 0;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            if (bus.vec_rd_req === 1'b1 || bus.busy !== 1'b1) pulses++;
        end
        n_vec++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL %s wait: got %0d bad cycles (extra req or not busy) expected 0", name, pulses);
        end
        bus.vec_rd_data  = data;
        bus.vec_rd_valid = 1'b1;
        @(negedge clk);
        bus.vec_rd_valid = 1'b0;
        for (int i = 0; i < LANES; i++) m_buf[i] = data[i*32 +: 32];
        m_mask = '0;
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s done: got busy=%b expected 0", name, bus.busy);
        end
    endtask

    task automatic test_fetch();
        logic [255:0] d;
        logic [31:0]  v;
        for (int i = 0; i < LANES; i++) d[i*32 +: 32] = $urandom;
        d[255:224] = 32'hCAFE;
        do_fetch(5, 6, d, "fetch");
        bus_read(BASE + 7, v);
        n_vec++;
        if (v !== 32'hCAFE) begin
            n_err++;
            $display("FAIL fetch lane7: got %h expected %h", v, 32'hCAFE);
        end
        read_lanes("fetch");
        read_status("fetch");
        bus.vec_rd_data  = {LANES{32'hBADBAD00}};
        bus.vec_rd_valid = 1'b1;
        @(negedge clk);
        bus.vec_rd_valid = 1'b0;
        read_lanes("stray_valid");
    endtask

    task automatic test_errors();
        logic [255:0] d;
        bus_write(A_COMMIT, NREGS);
        @(negedge clk);
        n_vec++;
        if (bus.vec_wr_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL bad commit idx: got v=%b busy=%b expected 0 0", bus.vec_wr_valid, bus.busy);
        end
        m_err = 1'b1;
        read_status("bad_commit");
        bus_write(A_STATUS, 32'h1);
        read_status("no_clear");
        bus_write(A_STATUS, 32'h2);
        m_err = 1'b0;
        read_status("clear");

        bus_write(A_FETCH, 9);
        n_vec++;
        if (bus.vec_rd_req !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL bad fetch idx: got rq=%b busy=%b expected 0 0", bus.vec_rd_req, bus.busy);
        end
        m_err = 1'b1;
        read_status("bad_fetch");
        bus_write(A_STATUS, 32'h2);
        m_err = 1'b0;

        bus.vec_wr_ready = 1'b0;
        bus_write(A_COMMIT, 4);
        bus_write(BASE, 32'h12345678);
        m_err = 1'b1;
        @(negedge clk);
        bus.vec_wr_ready = 1'b1;
        bus.addr = ADDR_W'(BASE + 1); bus.wdata = 32'h87654321; bus.we = 1'b1;
        @(negedge clk);
        bus.we = 1'b0;
        bus.vec_wr_ready = 1'b0;
        m_mask = '0;
        n_vec++;
        if (bus.vec_wr_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy commit end: got v=%b busy=%b expected 0 0", bus.vec_wr_valid, bus.busy);
        end
        read_lanes("busy_write");
        read_status("busy_write");
        bus_write(A_STATUS, 32'h2);
        m_err = 1'b0;

        // Commit attempted while a fetch is outstanding is rejected.
        for (int i = 0; i < LANES; i++) d[i*32 +: 32] = $urandom;
        bus_write(A_FETCH, 2);
        bus_write(A_COMMIT, 3);
        n_vec++;
        if (bus.vec_wr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL commit during fetch: got v=%b expected 0", bus.vec_wr_valid);
        end
        m_err = 1'b1;
        bus.vec_rd_data  = d;
        bus.vec_rd_valid = 1'b1;
        @(negedge clk);
        bus.vec_rd_valid = 1'b0;
        for (int i = 0; i < LANES; i++) m_buf[i] = d[i*32 +: 32];
        m_mask = '0;
        read_status("fetch_busy");
        read_lanes("fetch_busy");
        bus_write(A_STATUS, 32'h2);
        m_err = 1'b0;
    endtask

    task automatic test_reset_mid_commit();
        for (int i = 0; i < 4; i++) lane_write(i, $urandom);
        bus.vec_wr_ready = 1'b0;
        bus_write(A_COMMIT, 6);
        n_vec++;
        if (bus.vec_wr_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pre-reset commit: got v=%b expected 1", bus.vec_wr_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        n_vec++;
        if (bus.vec_wr_valid !== 1'b0 || bus.busy !== 1'b0 || bus.vec_wr_idx !== 3'd0) begin
            n_err++;
            $display("FAIL mid-commit reset: got v=%b busy=%b idx=%0d expected 0 0 0",
                     bus.vec_wr_valid, bus.busy, bus.vec_wr_idx);
        end
        read_lanes("rst_mid");
        read_status("rst_mid");
    endtask

    task automatic test_random();
        logic [255:0] d;
        logic [31:0]  v;
        int idx, lat;
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 3))
                0: lane_write($urandom_range(0, LANES - 1), $urandom);
                1: begin
                    idx = $urandom_range(0, LANES - 1);
                    bus_read(BASE + idx, v);
                    n_vec++;
                    if (v !== m_buf[idx]) begin
                        n_err++;
                        $display("FAIL rand lane%0d: got %h expected %h", idx, v, m_buf[idx]);
                    end
                end
                2: begin
                    idx = $urandom_range(0, NREGS - 1);
                    lat = $urandom_range(0, 3);
                    bus.vec_wr_ready = 1'b0;
                    bus_write(A_COMMIT, idx);
                    n_vec++;
                    if (bus.vec_wr_valid !== 1'b1 || bus.vec_wr_idx !== 3'(idx) || bus.vec_wr_data !== exp_vec()) begin
                        n_err++;
                        $display("FAIL rand commit: got v=%b idx=%0d data=%h expected v=1 idx=%0d data=%h",
                                 bus.vec_wr_valid, bus.vec_wr_idx, bus.vec_wr_data, idx, exp_vec());
                    end
                    repeat (lat) @(negedge clk);
                    bus.vec_wr_ready = 1'b1;
                    @(negedge clk);
                    bus.vec_wr_ready = 1'b0;
                    m_mask = '0;
                end
                default: begin
                    for (int i = 0; i < LANES; i++) d[i*32 +: 32] = $urandom;
                    do_fetch($urandom_range(0, NREGS - 1), $urandom_range(0, 4), d, "rand_fetch");
                end
            endcase
            read_status("rand");
        end
        read_lanes("rand_end");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.addr = '0; bus.wdata = '0; bus.we = 1'b0;
        bus.vec_wr_ready = 1'b0; bus.vec_rd_valid = 1'b0; bus.vec_rd_data = '0;
        test_reset();
        test_lane_loads();
        test_commit_backpressure();
        test_partial_commit();
        test_fetch();
        test_errors();
        test_reset_mid_commit();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
